// File: rtl/uart_pkg.sv
// Shared UART types and helpers: receiver state encoding, parity modes and the
// majority vote used by the input noise filter.
package uart_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop,
    StWaitIdle
  } rx_state_e;

  localparam int unsigned PAR_NONE = 0;
  localparam int unsigned PAR_EVEN = 1;
  localparam int unsigned PAR_ODD  = 2;

  function automatic logic majority3(input logic [2:0] s);
    return (s[0] & s[1]) | (s[0] & s[2]) | (s[1] & s[2]);
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Oversample tick generator: one-clk pulse every CLOCK_RATE/(BAUD_RATE*OVERSAMPLE)
// clocks while en is high; counter held at zero while disabled.
module uart_baud_tick #(
  parameter int unsigned CLOCK_RATE = 50000000,
  parameter int unsigned BAUD_RATE  = 9600,
  parameter int unsigned OVERSAMPLE = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  output logic tick
);

  localparam int unsigned DIV = CLOCK_RATE / (BAUD_RATE * OVERSAMPLE);
  localparam int unsigned CW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DIV - 1);

  if (DIV < 2) begin : g_bad_div
    $error("uart_baud_tick: clock divider must be at least 2");
  end

  logic [CW-1:0] cnt_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
      tick  <= 1'b0;
    end else if (!en) begin
      cnt_q <= '0;
      tick  <= 1'b0;
    end else if (cnt_q == CNT_MAX) begin
      cnt_q <= '0;
      tick  <= 1'b1;
    end else begin
      cnt_q <= cnt_q + 1'b1;
      tick  <= 1'b0;
    end
  end

endmodule

// File: rtl/uart_rx_param.sv
// Parametrised UART receiver with one-entry holding register and error pulses.
// Optional UART_RX_BREAK_DET_EN adds a break_det level output.
module uart_rx_param
  import uart_pkg::*;
#(
  parameter int unsigned CLOCK_RATE = 50000000,
  parameter int unsigned BAUD_RATE  = 9600,
  parameter int unsigned OVERSAMPLE = 16,
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned PARITY     = 0,
  parameter int unsigned STOP_BITS  = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 en,
  input  logic                 in,
  output logic [DATA_BITS-1:0] out,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 err_frame,
  output logic                 err_parity,
  output logic                 err_overrun,
  output logic                 busy
`ifdef UART_RX_BREAK_DET_EN
  ,
  output logic                 break_det
`endif
);

  localparam int unsigned TW = $clog2(OVERSAMPLE);
  localparam logic [TW-1:0] TMAX  = TW'(OVERSAMPLE - 1);
  localparam logic [TW-1:0] TMID  = TW'(OVERSAMPLE / 2 - 2);
  localparam logic [3:0]    BLAST = 4'(DATA_BITS - 1);
  localparam logic [3:0]    SLAST = 4'(STOP_BITS - 1);

  if (OVERSAMPLE < 8 || OVERSAMPLE > 32 || (OVERSAMPLE % 2) != 0) begin : g_bad_os
    $error("uart_rx_param: OVERSAMPLE must be even and within 8..32");
  end
  if (DATA_BITS < 5 || DATA_BITS > 9 || PARITY > 2 || STOP_BITS < 1 || STOP_BITS > 2)
  begin : g_bad_fmt
    $error("uart_rx_param: unsupported frame format");
  end

  logic tick;

  uart_baud_tick #(
    .CLOCK_RATE(CLOCK_RATE),
    .BAUD_RATE (BAUD_RATE),
    .OVERSAMPLE(OVERSAMPLE)
  ) u_baud_tick (
    .clk  (clk),
    .reset(reset),
    .en   (en),
    .tick (tick)
  );

  rx_state_e            state_q;
  logic [2:0]           filt_q;
  logic [TW-1:0]        tcnt_q;
  logic [3:0]           bcnt_q;
  logic [DATA_BITS-1:0] shift_q;
  logic                 perr_q;
  logic                 bit_val;
  logic                 par_exp;
`ifdef UART_RX_BREAK_DET_EN
  logic                 par_bit_q;
`endif

  assign bit_val = majority3(filt_q);
  assign par_exp = (PARITY == PAR_ODD) ? ~^shift_q : ^shift_q;
  assign busy    = (state_q != StIdle);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      filt_q      <= 3'b111;
      tcnt_q      <= '0;
      bcnt_q      <= '0;
      shift_q     <= '0;
      perr_q      <= 1'b0;
      out         <= '0;
      out_valid   <= 1'b0;
      err_frame   <= 1'b0;
      err_parity  <= 1'b0;
      err_overrun <= 1'b0;
`ifdef UART_RX_BREAK_DET_EN
      par_bit_q   <= 1'b0;
      break_det   <= 1'b0;
`endif
    end else begin
      err_frame   <= 1'b0;
      err_parity  <= 1'b0;
      err_overrun <= 1'b0;
      // A later load in the same cycle overrides this clear.
      if (out_valid && out_ready) out_valid <= 1'b0;

      if (!en) begin
        state_q <= StIdle;
        filt_q  <= 3'b111;
        tcnt_q  <= '0;
        bcnt_q  <= '0;
        perr_q  <= 1'b0;
`ifdef UART_RX_BREAK_DET_EN
        break_det <= 1'b0;
`endif
      end else if (tick) begin
        filt_q <= {filt_q[1:0], in};
        case (state_q)
          StIdle: begin
            if (!bit_val) begin
              state_q <= StStart;
              tcnt_q  <= '0;
            end
          end
          StStart: begin
            if (tcnt_q == TMID) begin
              tcnt_q <= '0;
              bcnt_q <= '0;
              perr_q <= 1'b0;
              state_q <= bit_val ? StIdle : StData;
            end else begin
              tcnt_q <= tcnt_q + 1'b1;
            end
          end
          StData: begin
            if (tcnt_q == TMAX) begin
              tcnt_q  <= '0;
              shift_q <= {bit_val, shift_q[DATA_BITS-1:1]};
              if (bcnt_q == BLAST) begin
                bcnt_q  <= '0;
                state_q <= (PARITY != PAR_NONE) ? StParity : StStop;
              end else begin
                bcnt_q <= bcnt_q + 4'd1;
              end
            end else begin
              tcnt_q <= tcnt_q + 1'b1;
            end
          end
          StParity: begin
            if (tcnt_q == TMAX) begin
              tcnt_q  <= '0;
              perr_q  <= (bit_val != par_exp);
              state_q <= StStop;
`ifdef UART_RX_BREAK_DET_EN
              par_bit_q <= bit_val;
`endif
            end else begin
              tcnt_q <= tcnt_q + 1'b1;
            end
          end
          StStop: begin
            if (tcnt_q == TMAX) begin
              tcnt_q <= '0;
              if (!bit_val) begin
                state_q <= StWaitIdle;
`ifdef UART_RX_BREAK_DET_EN
                if (shift_q == '0 && (PARITY == PAR_NONE || !par_bit_q)) break_det <= 1'b1;
                else err_frame <= 1'b1;
`else
                err_frame <= 1'b1;
`endif
              end else if (bcnt_q == SLAST) begin
                bcnt_q  <= '0;
                state_q <= StIdle;
                if (perr_q) begin
                  err_parity <= 1'b1;
                end else if (out_valid && !out_ready) begin
                  err_overrun <= 1'b1;
                end else begin
                  out       <= shift_q;
                  out_valid <= 1'b1;
                end
              end else begin
                bcnt_q <= bcnt_q + 4'd1;
              end
            end else begin
              tcnt_q <= tcnt_q + 1'b1;
            end
          end
          StWaitIdle: begin
            if (bit_val) begin
              state_q <= StIdle;
`ifdef UART_RX_BREAK_DET_EN
              break_det <= 1'b0;
`endif
            end
          end
          default: state_q <= StIdle;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_param.sv
// Directed bench: 8N1 receiver (dut0) and 7E1 receiver (dut1), DIV=10, 160 clk per bit.
`timescale 1ns/1ps
module tb_uart_rx_param;

  localparam int unsigned CR = 1600000;
  localparam int unsigned BR = 10000;
  localparam int unsigned OS = 16;
  localparam int BT = 160;

  logic clk = 1'b0;
  logic reset = 1'b1;

  logic       en0 = 1'b1, in0 = 1'b1, rdy0 = 1'b1;
  logic [7:0] out0;
  logic       ov0, ef0, ep0, eo0, busy0;
  logic       en1 = 1'b1, in1 = 1'b1, rdy1 = 1'b1;
  logic [6:0] out1;
  logic       ov1, ef1, ep1, eo1, busy1;
`ifdef UART_RX_BREAK_DET_EN
  logic       bd0, bd1;
`endif

  always #5 clk = ~clk;

  uart_rx_param #(
    .CLOCK_RATE(CR), .BAUD_RATE(BR), .OVERSAMPLE(OS),
    .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)
  ) dut0 (
    .clk(clk), .reset(reset), .en(en0), .in(in0),
    .out(out0), .out_valid(ov0), .out_ready(rdy0),
    .err_frame(ef0), .err_parity(ep0), .err_overrun(eo0), .busy(busy0)
`ifdef UART_RX_BREAK_DET_EN
    , .break_det(bd0)
`endif
  );

  uart_rx_param #(
    .CLOCK_RATE(CR), .BAUD_RATE(BR), .OVERSAMPLE(OS),
    .DATA_BITS(7), .PARITY(1), .STOP_BITS(1)
  ) dut1 (
    .clk(clk), .reset(reset), .en(en1), .in(in1),
    .out(out1), .out_valid(ov1), .out_ready(rdy1),
    .err_frame(ef1), .err_parity(ep1), .err_overrun(eo1), .busy(busy1)
`ifdef UART_RX_BREAK_DET_EN
    , .break_det(bd1)
`endif
  );

  int n_checks = 0;
  int n_fail = 0;

  // Event monitor: counts pulses and captures delivered words.
  int         v0_rise, v0_hi, ef0_n, ep0_n, eo0_n;
  int         v1_rise, ef1_n, ep1_n, eo1_n;
  logic       ov0_p = 1'b0, ov1_p = 1'b0;
  logic [7:0] last0;
  logic [6:0] last1;
  bit         saw_busy0;

  always @(negedge clk) begin
    if (ov0 && !ov0_p) begin v0_rise++; last0 = out0; end
    if (ov0) v0_hi++;
    if (ef0) ef0_n++;
    if (ep0) ep0_n++;
    if (eo0) eo0_n++;
    if (busy0) saw_busy0 = 1'b1;
    if (ov1 && !ov1_p) begin v1_rise++; last1 = out1; end
    if (ef1) ef1_n++;
    if (ep1) ep1_n++;
    if (eo1) eo1_n++;
    ov0_p = ov0;
    ov1_p = ov1;
  end

  task automatic clr_counts();
    v0_rise = 0; v0_hi = 0; ef0_n = 0; ep0_n = 0; eo0_n = 0;
    v1_rise = 0; ef1_n = 0; ep1_n = 0; eo1_n = 0;
    last0 = '0; last1 = '0; saw_busy0 = 1'b0;
  endtask

  task automatic idle(input int nbits);
    repeat (nbits * BT) @(negedge clk);
  endtask

  task automatic drive0(input logic v);
    in0 = v;
    repeat (BT) @(negedge clk);
  endtask

  task automatic drive1(input logic v);
    in1 = v;
    repeat (BT) @(negedge clk);
  endtask

  task automatic send0(input logic [7:0] d, input logic stop);
    drive0(1'b0);
    for (int i = 0; i < 8; i++) drive0(d[i]);
    drive0(stop);
    in0 = 1'b1;
  endtask

  task automatic send1(input logic [6:0] d, input logic par);
    drive1(1'b0);
    for (int i = 0; i < 7; i++) drive1(d[i]);
    drive1(par);
    drive1(1'b1);
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    n_checks++;
    if ({out0, ov0, ef0, ep0, eo0, busy0} !== 13'h0) begin
      n_fail++;
      $display("FAIL reset_dut0: got %h want 0", {out0, ov0, ef0, ep0, eo0, busy0});
    end
    n_checks++;
    if ({out1, ov1, ef1, ep1, eo1, busy1} !== 12'h0) begin
      n_fail++;
      $display("FAIL reset_dut1: got %h want 0", {out1, ov1, ef1, ep1, eo1, busy1});
    end
    reset = 1'b0;
    idle(2);
  endtask

  task automatic test_8n1();
    clr_counts();
    send0(8'hA5, 1'b1);
    idle(1);
    n_checks++;
    if (last0 !== 8'hA5) begin n_fail++; $display("FAIL 8n1_data: got %h want a5", last0); end
    n_checks++;
    if (v0_rise !== 1 || v0_hi !== 1) begin
      n_fail++; $display("FAIL 8n1_valid: rises %0d cycles %0d want 1 1", v0_rise, v0_hi);
    end
    n_checks++;
    if (ef0_n + ep0_n + eo0_n !== 0) begin
      n_fail++; $display("FAIL 8n1_errs: got %0d want 0", ef0_n + ep0_n + eo0_n);
    end
  endtask

  task automatic test_parity();
    clr_counts();
    send1(7'h55, 1'b0);  // 0x55 has four ones: even parity bit is 0
    idle(1);
    n_checks++;
    if (last1 !== 7'h55 || v1_rise !== 1) begin
      n_fail++; $display("FAIL par_good: data %h rises %0d want 55 1", last1, v1_rise);
    end
    n_checks++;
    if (ep1_n !== 0) begin n_fail++; $display("FAIL par_good_err: got %0d want 0", ep1_n); end
    clr_counts();
    send1(7'h55, 1'b1);
    idle(1);
    n_checks++;
    if (ep1_n !== 1) begin n_fail++; $display("FAIL par_bad_err: got %0d want 1", ep1_n); end
    n_checks++;
    if (v1_rise !== 0 || ov1 !== 1'b0) begin
      n_fail++; $display("FAIL par_bad_valid: rises %0d ov %b want 0 0", v1_rise, ov1);
    end
  endtask

  task automatic test_frame_err();
    clr_counts();
    send0(8'h81, 1'b0);
    in0 = 1'b0;
    idle(3);
    in0 = 1'b1;
    idle(2);
    n_checks++;
    if (ef0_n !== 1 || v0_rise !== 0) begin
      n_fail++; $display("FAIL frame_err: errs %0d rises %0d want 1 0", ef0_n, v0_rise);
    end
    n_checks++;
    if (busy0 !== 1'b0) begin n_fail++; $display("FAIL frame_idle: busy %b want 0", busy0); end
    send0(8'h3C, 1'b1);
    idle(1);
    n_checks++;
    if (last0 !== 8'h3C || v0_rise !== 1 || ef0_n !== 1) begin
      n_fail++;
      $display("FAIL frame_recover: data %h rises %0d ferr %0d want 3c 1 1", last0, v0_rise, ef0_n);
    end
  endtask

  task automatic test_overrun();
    clr_counts();
    rdy0 = 1'b0;
    send0(8'h11, 1'b1);
    idle(1);
    send0(8'h22, 1'b1);
    idle(1);
    n_checks++;
    if (out0 !== 8'h11 || ov0 !== 1'b1) begin
      n_fail++; $display("FAIL ovr_hold: out %h valid %b want 11 1", out0, ov0);
    end
    n_checks++;
    if (eo0_n !== 1) begin n_fail++; $display("FAIL ovr_pulse: got %0d want 1", eo0_n); end
    rdy0 = 1'b1;
    @(negedge clk);
    n_checks++;
    if (ov0 !== 1'b0) begin n_fail++; $display("FAIL ovr_accept: valid %b want 0", ov0); end
  endtask

  task automatic test_glitch();
    clr_counts();
    in0 = 1'b0;
    repeat (4 * 10) @(negedge clk);  // four oversample ticks
    in0 = 1'b1;
    idle(2);
    n_checks++;
    if (saw_busy0 !== 1'b1 || busy0 !== 1'b0) begin
      n_fail++; $display("FAIL glitch_busy: seen %b now %b want 1 0", saw_busy0, busy0);
    end
    n_checks++;
    if (v0_rise + ef0_n + ep0_n + eo0_n !== 0) begin
      n_fail++; $display("FAIL glitch_quiet: events %0d want 0", v0_rise + ef0_n + ep0_n + eo0_n);
    end
  endtask

  task automatic test_reset_en();
    clr_counts();
    drive0(1'b0);
    drive0(1'b1);
    drive0(1'b0);
    repeat (20) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({out0, ov0, busy0} !== 10'h0) begin
      n_fail++; $display("FAIL midreset: got %h want 0", {out0, ov0, busy0});
    end
    in0 = 1'b1;
    reset = 1'b0;
    idle(2);
    rdy0 = 1'b0;
    send0(8'h5A, 1'b1);
    idle(1);
    drive0(1'b0);
    drive0(1'b1);
    drive0(1'b1);
    repeat (30) @(negedge clk);
    en0 = 1'b0;
    repeat (5) @(negedge clk);
    n_checks++;
    if (busy0 !== 1'b0 || ov0 !== 1'b1 || out0 !== 8'h5A) begin
      n_fail++; $display("FAIL en_low: busy %b valid %b out %h want 0 1 5a", busy0, ov0, out0);
    end
    in0 = 1'b1;
    en0 = 1'b1;
    rdy0 = 1'b1;
    idle(2);
    n_checks++;
    if (ef0_n + ep0_n + eo0_n !== 0) begin
      n_fail++; $display("FAIL en_drop_errs: got %0d want 0", ef0_n + ep0_n + eo0_n);
    end
    clr_counts();
    send0(8'hF0, 1'b1);
    idle(1);
    n_checks++;
    if (last0 !== 8'hF0 || v0_rise !== 1) begin
      n_fail++; $display("FAIL after_en: data %h rises %0d want f0 1", last0, v0_rise);
    end
  endtask

  initial begin
    clr_counts();
    test_reset();
    test_8n1();
    test_parity();
    test_frame_err();
    test_overrun();
    test_glitch();
    test_reset_en();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
